// File: rtl/ljpeg_pkg.sv
// Shared types and constants for the LJPEG row-buffer control path.
package ljpeg_pkg;

    localparam int unsigned PIXEL_BITS      = 12;
    localparam int unsigned PIXELS_PER_WORD = 16;
    localparam int unsigned ROW_WORDS       = 32;
    localparam int unsigned ROW_BITS        = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ljpeg_frame_counter.sv
// Word/row position counter for one frame; freezes on the frame's last word.
module ljpeg_frame_counter
    import ljpeg_pkg::*;
#(
    parameter int unsigned ROW_WORDS = ljpeg_pkg::ROW_WORDS,
    parameter int unsigned ROW_BITS  = ljpeg_pkg::ROW_BITS,
    localparam int unsigned WIDX_BITS = $clog2(ROW_WORDS)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [ROW_BITS-1:0]  rows,
    output logic [WIDX_BITS-1:0] word_idx,
    output logic [ROW_BITS-1:0]  row_idx,
    output logic                 last_c
);

    logic row_end_c;

    assign row_end_c = (word_idx == WIDX_BITS'(ROW_WORDS - 1));
    assign last_c    = row_end_c && (row_idx == rows - ROW_BITS'(1));

    // word_idx wraps naturally because ROW_WORDS is a power of two
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            word_idx <= '0;
            row_idx  <= '0;
        end else if (clear) begin
            word_idx <= '0;
            row_idx  <= '0;
        end else if (inc && !last_c) begin
            word_idx <= word_idx + WIDX_BITS'(1);
            if (row_end_c) begin
                row_idx <= row_idx + ROW_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/ljpeg_buffer_sequencer.sv
// Sequences the row buffer: clear at frame start, gate the pixel stream, flush at frame end.
module ljpeg_buffer_sequencer
    import ljpeg_pkg::*;
#(
    parameter int unsigned ROW_WORDS = ljpeg_pkg::ROW_WORDS,
    parameter int unsigned ROW_BITS  = ljpeg_pkg::ROW_BITS,
    localparam int unsigned WIDX_BITS = $clog2(ROW_WORDS)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ROW_BITS-1:0]  cfg_rows,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic                 down_ready,
    output logic                 buf_rst,
    output logic                 input_valid,
    output logic                 pause_signal,
    output logic                 end_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err_cfg,
    output logic [WIDX_BITS-1:0] word_idx,
    output logic [ROW_BITS-1:0]  row_idx
);

    state_e              state;
    state_e              state_nxt;
    logic [ROW_BITS-1:0] rows_reg;
    logic                abort_q;
    logic                err_nxt;
    logic                accept_c;
    logic                last_c;
    logic                clear_c;
    logic                abort_c;

    assign clear_c = (state == ST_IDLE) && start && (cfg_rows != '0);
    assign abort_c = abort && (state != ST_IDLE);
    assign buf_rst = sys_rst || (state == ST_CLEAR) || abort_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            rows_reg <= '0;
            abort_q  <= 1'b0;
            err_cfg  <= 1'b0;
        end else begin
            state   <= state_nxt;
            abort_q <= abort_c;
            err_cfg <= err_nxt;
            if (clear_c) begin
                rows_reg <= cfg_rows;
            end
        end
    end

    // Next state and buffer-stage controls
    always_comb begin
        state_nxt    = state;
        up_ready     = 1'b0;
        input_valid  = 1'b0;
        pause_signal = 1'b1;
        end_in       = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        err_nxt      = 1'b0;
        accept_c     = 1'b0;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (cfg_rows != '0) begin
                        state_nxt = ST_CLEAR;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                up_ready     = down_ready;
                pause_signal = ~down_ready;
                input_valid  = up_valid & down_ready;
                accept_c     = input_valid;
                if (accept_c && last_c) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                end_in       = 1'b1;
                pause_signal = ~down_ready;
                if (down_ready) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (abort_c) begin
            state_nxt = ST_IDLE;
        end
    end

    ljpeg_frame_counter #(
        .ROW_WORDS (ROW_WORDS),
        .ROW_BITS  (ROW_BITS)
    ) u_frame_counter (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clear    (clear_c),
        .inc      (accept_c),
        .rows     (rows_reg),
        .word_idx (word_idx),
        .row_idx  (row_idx),
        .last_c   (last_c)
    );

endmodule

// File: tb/tb_ljpeg_buffer_sequencer.sv
// Randomized self-checking bench for ljpeg_buffer_sequencer against a frame-level reference model.
module tb_ljpeg_buffer_sequencer;

    localparam int unsigned RW = 32;
    localparam int unsigned RB = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          start;
    logic          abort;
    logic [RB-1:0] cfg_rows;
    logic          up_valid;
    logic          up_ready;
    logic          down_ready;
    logic          buf_rst;
    logic          input_valid;
    logic          pause_signal;
    logic          end_in;
    logic          busy;
    logic          done;
    logic          err_cfg;
    logic [4:0]    word_idx;
    logic [RB-1:0] row_idx;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    ljpeg_buffer_sequencer #(
        .ROW_WORDS (RW),
        .ROW_BITS  (RB)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .abort        (abort),
        .cfg_rows     (cfg_rows),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .down_ready   (down_ready),
        .buf_rst      (buf_rst),
        .input_valid  (input_valid),
        .pause_signal (pause_signal),
        .end_in       (end_in),
        .busy         (busy),
        .done         (done),
        .err_cfg      (err_cfg),
        .word_idx     (word_idx),
        .row_idx      (row_idx)
    );

    // Control bundle order: up_ready pause input_valid end_in done busy buf_rst err_cfg
    function automatic logic [7:0] ctl(input bit ur, input bit p, input bit iv, input bit e,
                                       input bit d, input bit b, input bit br, input bit er);
        return {ur, p, iv, e, d, b, br, er};
    endfunction

    function automatic logic [7:0] obs();
        return {up_ready, pause_signal, input_valid, end_in, done, busy, buf_rst, err_cfg};
    endfunction

    function automatic bit coin(input int unsigned pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One frame. mode: 0 random, 1 full rate, 2 stall at word 10, 3 stall on flush entry,
    // 4 random with abort at accept count abort_at, 5 random with sys_rst during flush.
    task automatic run_frame(input int rows, input int mode, input int abort_at,
                             output int run_cyc, output int flush_cyc);
        int  n;
        int  total;
        int  stall;
        bit  uv;
        bit  dr;
        bit  abort_now;
        run_cyc   = 0;
        flush_cyc = 0;
        total     = rows * RW;
        stall     = 0;
        n         = 0;

        start      = 1'b1;
        cfg_rows   = RB'(rows);
        abort      = (mode == 0) ? coin(50) : 1'b0;
        up_valid   = coin(50);
        down_ready = coin(50);
        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL start_idle got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 0, 0, 0));
        end
        checks++;
        tick();

        start      = 1'b0;
        abort      = 1'b0;
        cfg_rows   = RB'($urandom);
        up_valid   = coin(50);
        down_ready = coin(50);
        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 0, 1, 1, 0)) begin
            errors++;
            $display("FAIL clear_ctl got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 1, 1, 0));
        end
        checks++;
        if (word_idx !== 5'd0 || row_idx !== RB'(0)) begin
            errors++;
            $display("FAIL clear_ctr got w%0d r%0d want w0 r0", word_idx, row_idx);
        end
        checks++;
        tick();

        while (n < total) begin
            if (run_cyc > 4000) begin
                errors++;
                checks++;
                $display("FAIL run_timeout got %0d accepts want %0d", n, total);
                return;
            end
            case (mode)
                0, 4, 5: begin uv = coin(75); dr = coin(75); end
                2: begin
                    uv = 1'b1;
                    dr = !(n == 10 && stall < 3);
                    if (!dr) stall++;
                end
                default: begin uv = 1'b1; dr = 1'b1; end
            endcase
            abort_now = (abort_at >= 0) && (n == abort_at);
            if (abort_now) uv = 1'b0;
            up_valid   = uv;
            down_ready = dr;
            abort      = abort_now;
            cfg_rows   = RB'($urandom);
            @(negedge sys_clk);
            if (obs() !== ctl(dr, !dr, uv & dr, 0, 0, 1, 0, 0)) begin
                errors++;
                $display("FAIL run_ctl n=%0d got %b want %b", n, obs(), ctl(dr, !dr, uv & dr, 0, 0, 1, 0, 0));
            end
            checks++;
            if (word_idx !== 5'(n % RW) || row_idx !== RB'(n / RW)) begin
                errors++;
                $display("FAIL run_ctr n=%0d got w%0d r%0d want w%0d r%0d", n, word_idx, row_idx, n % RW, n / RW);
            end
            checks++;
            if (uv && dr) n++;
            run_cyc++;
            tick();
            if (abort_now) begin
                abort      = 1'b0;
                up_valid   = 1'b1;
                down_ready = 1'b1;
                @(negedge sys_clk);
                if (obs() !== ctl(0, 1, 0, 0, 0, 0, 1, 0)) begin
                    errors++;
                    $display("FAIL abort_rst got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 0, 1, 0));
                end
                checks++;
                tick();
                @(negedge sys_clk);
                if (obs() !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin
                    errors++;
                    $display("FAIL abort_idle got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 0, 0, 0));
                end
                checks++;
                tick();
                return;
            end
        end

        // Frame-end flush: end_in held until downstream can take it
        do begin
            if (flush_cyc > 100) begin
                errors++;
                checks++;
                $display("FAIL flush_timeout got %0d cycles want <= 100", flush_cyc);
                return;
            end
            case (mode)
                0, 4: dr = coin(40);
                3:    dr = (flush_cyc >= 2);
                5:    dr = 1'b0;
                default: dr = 1'b1;
            endcase
            up_valid   = coin(50);
            down_ready = dr;
            if (mode == 5) sys_rst = 1'b1;
            @(negedge sys_clk);
            if (obs() !== ctl(0, !dr, 0, 1, 0, 1, mode == 5, 0)) begin
                errors++;
                $display("FAIL flush_ctl got %b want %b", obs(), ctl(0, !dr, 0, 1, 0, 1, mode == 5, 0));
            end
            checks++;
            if (word_idx !== 5'(RW - 1) || row_idx !== RB'(rows - 1)) begin
                errors++;
                $display("FAIL flush_ctr got w%0d r%0d want w%0d r%0d", word_idx, row_idx, RW - 1, rows - 1);
            end
            checks++;
            flush_cyc++;
            tick();
            if (mode == 5) begin
                sys_rst = 1'b0;
                @(negedge sys_clk);
                if (obs() !== ctl(0, 1, 0, 0, 0, 0, 0, 0) || word_idx !== 5'd0 || row_idx !== RB'(0)) begin
                    errors++;
                    $display("FAIL rst_flush got %b w%0d r%0d want %b w0 r0", obs(), word_idx, row_idx,
                             ctl(0, 1, 0, 0, 0, 0, 0, 0));
                end
                checks++;
                tick();
                return;
            end
        end while (!dr);

        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 1, 1, 0, 0)) begin
            errors++;
            $display("FAIL done_ctl got %b want %b", obs(), ctl(0, 1, 0, 0, 1, 1, 0, 0));
        end
        checks++;
        tick();
        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL post_done got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 0, 0, 0));
        end
        checks++;
        tick();
    endtask

    task automatic test_reset();
        sys_rst    = 1'b1;
        start      = 1'b1;
        abort      = 1'b0;
        cfg_rows   = RB'(3);
        up_valid   = 1'b1;
        down_ready = 1'b1;
        tick();
        tick();
        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 0, 0, 1, 0) || word_idx !== 5'd0 || row_idx !== RB'(0)) begin
            errors++;
            $display("FAIL reset_vals got %b w%0d r%0d want %b w0 r0", obs(), word_idx, row_idx,
                     ctl(0, 1, 0, 0, 0, 0, 1, 0));
        end
        checks++;
        tick();
        sys_rst = 1'b0;
        start   = 1'b0;
        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_release got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 0, 0, 0));
        end
        checks++;
        tick();
    endtask

    task automatic test_full_rate();
        int rc;
        int fc;
        run_frame(2, 1, -1, rc, fc);
        if (rc !== 64 || fc !== 1) begin
            errors++;
            $display("FAIL full_rate_len got run %0d flush %0d want run 64 flush 1", rc, fc);
        end
        checks++;
    endtask

    task automatic test_pause();
        int rc;
        int fc;
        run_frame(1, 2, -1, rc, fc);
        if (rc !== 35) begin
            errors++;
            $display("FAIL pause_len got %0d want 35", rc);
        end
        checks++;
    endtask

    task automatic test_flush_stall();
        int rc;
        int fc;
        run_frame(1, 3, -1, rc, fc);
        if (fc !== 3) begin
            errors++;
            $display("FAIL flush_stall_len got %0d want 3", fc);
        end
        checks++;
    endtask

    task automatic test_cfg_zero();
        start    = 1'b1;
        cfg_rows = RB'(0);
        abort    = coin(50);
        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL cfg0_start got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 0, 0, 0));
        end
        checks++;
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        cfg_rows = RB'(5);
        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 0, 0, 0, 1)) begin
            errors++;
            $display("FAIL cfg0_err got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 0, 0, 1));
        end
        checks++;
        tick();
        @(negedge sys_clk);
        if (obs() !== ctl(0, 1, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL cfg0_after got %b want %b", obs(), ctl(0, 1, 0, 0, 0, 0, 0, 0));
        end
        checks++;
        tick();
    endtask

    task automatic test_abort();
        int rc;
        int fc;
        run_frame(4, 4, RW + 5, rc, fc);
        run_frame(2, 1, -1, rc, fc);
        if (rc !== 64) begin
            errors++;
            $display("FAIL abort_restart_len got %0d want 64", rc);
        end
        checks++;
    endtask

    task automatic test_rst_flush();
        int rc;
        int fc;
        run_frame(1, 5, -1, rc, fc);
    endtask

    task automatic test_random();
        int rc;
        int fc;
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(1, 3)), 0, -1, rc, fc);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_pause();
        test_flush_stall();
        test_cfg_zero();
        test_abort();
        test_rst_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
